// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bus of the instruction fetch queue.
// The queue takes the slave modport; fetch and decode together take the master modport.
interface fetch_queue_if #(
  parameter int PTR_W = 2
);
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_ready;
  logic             flush;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// FIFO of {pc, instr} pairs between fetch and decode. The FIFO has a single-cycle flush.
// Both ends use valid/ready: a transfer occurs on an edge where valid & ready & ~flush.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          PTR_W     = 2,
  parameter logic [31:0] PC_IDLE   = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_pc_mem    [DEPTH];
  logic [31:0]      r_instr_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // in_ready comes only from registered occupancy, so decode stalls never reach fetch combinationally.
  assign w_in_ready  = (r_cnt != L_FULL);
  assign w_out_valid = (r_cnt != '0);
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage is not reset; a slot is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= bus.in_pc;
      r_instr_mem[r_wr_ptr] <= bus.in_instr;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : PC_IDLE;
  assign bus.out_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
  assign bus.count     = r_cnt;
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue directly downstream of the instruction memory / PC stage.
- Captures {pc, instr} pairs produced by fetch and buffers up to DEPTH entries in FIFO order.
- Presents the oldest entry to decode under a valid/ready handshake, which decouples fetch from decode stalls.
- A single-cycle flush empties the queue on a control-flow redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).
- PC_IDLE, 32'h00003000, value driven on out_pc while the queue is empty (the text base address).
- NOP_INSTR, 32'h00000000, value driven on out_instr while the queue is empty.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset==0 resets the block).
- in_valid  input  1  fetch offers an entry this cycle.
- in_pc  input  32  PC of the offered instruction.
- in_instr  input  32  instruction word at in_pc.
- in_ready  output  1  queue can accept an entry this cycle.
- out_valid  output  1  head entry is valid.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  discard all contents (redirect).
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array pc_mem/instr_mem[DEPTH], wr_ptr, rd_ptr (PTR_W bits), cnt (PTR_W+1 bits).
- Reset (reset==0, asynchronous): wr_ptr=0, rd_ptr=0, cnt=0. Storage contents are not reset.
- While in reset: in_ready=1, out_valid=0, out_pc=PC_IDLE, out_instr=NOP_INSTR, count=0.
- Release of reset is sampled at the next rising edge. Operation starts on the first edge with reset==1.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = (cnt != DEPTH).
  - Registered-state only; it does not depend on out_ready, so there is no combinational path from decode back to fetch.
  - When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (cnt != 0).
- out_pc/out_instr:
  - Combinational read of pc_mem/instr_mem[rd_ptr] when out_valid=1.
  - PC_IDLE/NOP_INSTR when empty.
  - No fall-through: an entry pushed at edge N is visible on the outputs after edge N. Minimum latency from in_valid to out_valid is 1 cycle.
- Push at a rising edge: write both arrays at wr_ptr, then wr_ptr += 1 (mod DEPTH, natural wrap).
- Pop at a rising edge: rd_ptr += 1 (mod DEPTH).
- cnt update: +1 on push only, -1 on pop only, unchanged on push & pop or on neither.
- Simultaneous push and pop:
  - Legal when 0 < cnt < DEPTH; occupancy is unchanged.
  - When cnt==0, pop cannot happen because out_valid=0, so only the push takes effect.
- Flush at a rising edge:
  - wr_ptr=rd_ptr=0, cnt=0.
  - Any in_valid or out_ready in that cycle is ignored: no write, no consume.
  - The cycle after a flush: out_valid=0, in_ready=1.
- Entries are delivered strictly in push order, with pc and instr always kept paired.
- The block performs no PC arithmetic; in_pc is stored verbatim.
- Holding rule: while out_valid=1 and out_ready=0, out_pc/out_instr stay stable until a pop or flush.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Test Plan:
- Reset/idle:
  - Stimulus: hold reset=0, then release; no input.
  - Required: out_valid=0, in_ready=1, count=0, out_pc=32'h00003000, out_instr=0.
- Fill to full:
  - Stimulus: push pc 0x3000,0x3004,0x3008,0x300C with instrs 0x34010001..0x34010004; out_ready=0.
  - Required: count steps 1..4; in_ready=0 after the 4th push; out_pc=0x3000 and out_instr=0x34010001 held throughout.
  - Then a 5th push is attempted with in_valid=1 while full → refused, count stays 4.
- Drain with wrap:
  - Stimulus: from full, pop 2, push 0x3010 and 0x3014, then pop all.
  - Required: output order is 0x3000,0x3004,0x3008,0x300C,0x3010,0x3014; the pointers wrap; count reaches 0; then out_pc=0x3000 (PC_IDLE).
- Concurrent push/pop:
  - Stimulus: with count=2, assert in_valid and out_ready for 10 cycles with pc incrementing by 4.
  - Required: count stays 2 every cycle; outputs lag inputs by exactly 2 entries.
- Flush priority:
  - Stimulus: with count=3, assert flush together with in_valid (pc 0x4000) and out_ready.
  - Required: next cycle count=0, out_valid=0, in_ready=1; entry 0x4000 absent; the next push (0x4004) appears at the head.
- Async reset mid-stream:
  - Stimulus: with count=3, drop reset between clock edges.
  - Required: count=0 and out_valid=0 immediately, without waiting for an edge; after release, the first push is delivered correctly.
